dsp_fod_qualifier: RTL and testbench
====================================

Name: dsp_fod_qualifier

Overview:
Downstream consumer of the FOD DSP chain's per-window detection flag. Applies M-of-N qualification over the most recent N averaging windows to reject single-window false triggers. Raises a latched alarm with a one-cycle alarm pulse and counts qualified events. Requires a software clear followed by a clean-window holdoff before it re-arms.

Parameters:
N_WINDOWS, 8, history depth in averaging windows (1..32)
M_HITS, 5, detections within history required to alarm (1..N_WINDOWS)
HOLDOFF_WIN, 2, consecutive clean windows required after clear before re-arm (0..255)
CNT_W, 16, width of saturating event counter

Ports:
i_clk  in  1  100 MHz system clock
i_rstn  in  1  asynchronous active-low reset
i_enable  in  1  qualifier enable; low forces IDLE
i_window  in  1  one-cycle pulse: averaging window completed (averager valid)
i_detected  in  1  one-cycle detection flag; sampled only when i_window=1
i_clear  in  1  one-cycle alarm clear / history flush
o_alarm  out  1  latched alarm level
o_alarm_pulse  out  1  one-cycle pulse on entry to ALARM
o_hit_count  out  $clog2(N_WINDOWS+1)  popcount of history register
o_event_count  out  CNT_W  qualified alarm count, saturating
o_state  out  2  IDLE=0, ARMED=1, ALARM=2, HOLDOFF=3

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rstn.
- Reset values: state=IDLE, history=0, holdoff counter=0. All outputs 0.
- All outputs are registered. An i_window event at cycle t is reflected on o_hit_count, o_alarm, o_alarm_pulse and o_state at t+1.
- i_detected without i_window is ignored.
- History is an N_WINDOWS-bit shift register. On an accepted window it becomes {history[N-2:0], i_detected}, and the oldest bit drops.
- o_hit_count is the popcount of the post-update history.
- Priority, highest first: i_enable=0, then i_clear, then i_window.
- i_enable=0, any state: next state IDLE; history and holdoff counter cleared; o_alarm=0; o_event_count retained.
- IDLE: i_enable=1 -> ARMED next cycle. Windows arriving in IDLE are discarded.
- ARMED, i_window:
  - Shift history.
  - If the new popcount >= M_HITS: go to ALARM, pulse o_alarm_pulse for 1 cycle, increment o_event_count (saturating at 2^CNT_W-1).
- ARMED, i_clear: flush history to 0, stay ARMED, discard any coincident window.
- ALARM: o_alarm=1. History keeps shifting on windows (o_hit_count stays live). No further pulses or counts.
- ALARM, i_clear: go to HOLDOFF; history=0; holdoff counter=0; coincident window discarded.
- HOLDOFF: o_alarm=0; history frozen at 0.
  - i_window with i_detected=0 increments the holdoff counter.
  - i_window with i_detected=1 resets the counter to 0.
  - When the counter reaches HOLDOFF_WIN, go to ARMED on the same t+1 edge.
  - HOLDOFF_WIN=0: HOLDOFF -> ARMED on the cycle after entry.
- HOLDOFF, i_clear: counter reset to 0.
- The alarm decision uses the popcount of the updated history in the same cycle; there is no extra pipeline stage.
- Reset asserted mid-ALARM or mid-HOLDOFF: all state is immediately cleared to reset values. The first accepted window after reset release and enable is treated as history bit 0.
- o_event_count is cleared only by reset.

Test Plan:
1. Defaults (N=8, M=5). Enable, then 5 windows all detected -> o_hit_count 1..5; o_alarm and a single o_alarm_pulse one cycle after the 5th window; o_event_count=1; o_state=2.
2. Windows 1,0,1,0,1,0,1,0 then eight 0-windows -> o_hit_count peaks at 4, no alarm, decays to 0. Then windows 1,1,0,1,0,1,1 -> alarm after the 7th (popcount 5).
3. In ALARM, pulse i_clear together with i_window(det=1) -> HOLDOFF, o_hit_count=0, o_alarm=0, window discarded. Then windows 0,1,0,0 -> ARMED after the 4th window (the detected window resets the holdoff counter).
4. Drop i_enable for 1 cycle while ARMED with o_hit_count=4 -> IDLE, hit count 0. Re-enable -> ARMED. Four detected windows -> no alarm, showing history was truly flushed.
5. CNT_W=2. Four alarm/clear/holdoff cycles -> o_event_count 1,2,3,3 (saturates). o_alarm_pulse still fires on every ALARM entry.
6. Assert i_rstn low asynchronously (mid-cycle) during ALARM -> o_alarm, o_state, o_hit_count and o_event_count go to 0 without waiting for a clock edge. i_detected pulses without i_window after release -> no history change.

Source files
------------

// File: rtl/dsp_fod_qualifier.sv
// M-of-N detection qualifier for the FOD DSP chain.
// The per-window detection flag is shifted into an N-window history. When the
// popcount of the history reaches M_HITS while ARMED, the alarm latches, a
// one-cycle pulse fires and a saturating event counter increments. After a
// software clear the block waits for HOLDOFF_WIN consecutive clean windows
// before re-arming.
module dsp_fod_qualifier #(
  parameter  int N_WINDOWS   = 8,
  parameter  int M_HITS      = 5,
  parameter  int HOLDOFF_WIN = 2,
  parameter  int CNT_W       = 16,
  localparam int HW          = $clog2(N_WINDOWS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic             i_window,
  input  logic             i_detected,
  input  logic             i_clear,
  output logic             o_alarm,
  output logic             o_alarm_pulse,
  output logic [HW-1:0]    o_hit_count,
  output logic [CNT_W-1:0] o_event_count,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ALARM   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [N_WINDOWS-1:0]   hist_q, hist_d;
  logic [7:0]             hold_q, hold_d;
  logic [CNT_W-1:0]       evt_q, evt_d;
  logic [HW-1:0]          hit_q, hit_d;
  logic                   alarm_q, alarm_d;
  logic                   pulse_q, pulse_d;

  function automatic logic [HW-1:0] popcnt(input logic [N_WINDOWS-1:0] v);
    logic [HW-1:0] c;
    c = '0;
    for (int i = 0; i < N_WINDOWS; i++) c = c + HW'(v[i]);
    return c;
  endfunction

  // Next-state, history, holdoff and event-count logic; priority is
  // enable, then clear, then window.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    hold_d  = hold_q;
    evt_d   = evt_q;
    pulse_d = 1'b0;
    if (!i_enable) begin
      state_d = IDLE;
      hist_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Windows arriving here are dropped; history starts clean.
          state_d = ARMED;
        end
        ARMED: begin
          if (i_clear) begin
            hist_d = '0;
          end else if (i_window) begin
            hist_d = (hist_q << 1) | N_WINDOWS'(i_detected);
            if (popcnt(hist_d) >= HW'(M_HITS)) begin
              state_d = ALARM;
              pulse_d = 1'b1;
              if (evt_q != {CNT_W{1'b1}}) evt_d = evt_q + 1'b1;
            end
          end
        end
        ALARM: begin
          if (i_clear) begin
            state_d = HOLDOFF;
            hist_d  = '0;
            hold_d  = '0;
          end else if (i_window) begin
            // Keep the hit count live while alarmed; no re-trigger.
            hist_d = (hist_q << 1) | N_WINDOWS'(i_detected);
          end
        end
        HOLDOFF: begin
          hist_d = '0;
          if (i_clear)                    hold_d = '0;
          else if (i_window && i_detected) hold_d = '0;
          else if (i_window)               hold_d = hold_q + 8'd1;
          // Compare the updated count so re-arm lands on the same edge
          // as the qualifying window (and immediately when HOLDOFF_WIN=0).
          if (hold_d >= 8'(HOLDOFF_WIN)) begin
            state_d = ARMED;
            hold_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    hit_d   = popcnt(hist_d);
    alarm_d = (state_d == ALARM);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      hist_q  <= '0;
      hold_q  <= '0;
      evt_q   <= '0;
      hit_q   <= '0;
      alarm_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      hold_q  <= hold_d;
      evt_q   <= evt_d;
      hit_q   <= hit_d;
      alarm_q <= alarm_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_alarm       = alarm_q;
  assign o_alarm_pulse = pulse_q;
  assign o_hit_count   = hit_q;
  assign o_event_count = evt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_dsp_fod_qualifier.sv
// Scoreboard bench for dsp_fod_qualifier. Directed steps push hand-computed
// expectations; a monitor pops one per clock and compares all outputs.
// A second instance with CNT_W=2 sees the same stimulus to exercise
// event-counter saturation.
module tb_dsp_fod_qualifier;

  logic i_clk = 1'b0;
  logic i_rstn, i_enable, i_window, i_detected, i_clear;
  logic       o_alarm, o_alarm_pulse;
  logic [3:0] o_hit_count;
  logic [15:0] o_event_count;
  logic [1:0] o_state;
  logic       a2, p2;
  logic [3:0] h2;
  logic [1:0] e2, s2;

  int errors = 0;
  int checks = 0;
  int e_evt  = 0;
  int e_evt2 = 0;

  typedef struct {
    int st;
    int hit;
    int pulse;
    int evt;
    int evt2;
  } exp_t;
  exp_t q[$];
  exp_t m;

  always #5 i_clk = ~i_clk;

  dsp_fod_qualifier u_dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_window(i_window),
    .i_detected(i_detected), .i_clear(i_clear), .o_alarm(o_alarm),
    .o_alarm_pulse(o_alarm_pulse), .o_hit_count(o_hit_count),
    .o_event_count(o_event_count), .o_state(o_state)
  );

  dsp_fod_qualifier #(.CNT_W(2)) u_dut2 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable), .i_window(i_window),
    .i_detected(i_detected), .i_clear(i_clear), .o_alarm(a2),
    .o_alarm_pulse(p2), .o_hit_count(h2),
    .o_event_count(e2), .o_state(s2)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic en, input logic win, input logic det,
                      input logic clr, input int st, input int hit,
                      input int pl);
    exp_t e;
    @(negedge i_clk);
    i_enable = en; i_window = win; i_detected = det; i_clear = clr;
    if (pl != 0) begin
      e_evt++;
      if (e_evt2 < 3) e_evt2++;
    end
    e.st = st; e.hit = hit; e.pulse = pl; e.evt = e_evt; e.evt2 = e_evt2;
    q.push_back(e);
  endtask

  // Five detected windows to alarm, then optionally clear and two clean
  // holdoff windows back to ARMED.
  task automatic alarm_cycle(input bit do_clear);
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 0, (i == 4) ? 2 : 1, i + 1, (i == 4) ? 1 : 0);
    step(1, 0, 0, 0, 2, 5, 0);
    if (do_clear) begin
      step(1, 0, 0, 1, 3, 0, 0);
      step(1, 1, 0, 0, 3, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0);
    end
  endtask

  // Monitor: outputs are stable 2 time units after each rising edge.
  always @(posedge i_clk) begin
    #2;
    if (q.size() > 0) begin
      m = q.pop_front();
      check("state",     int'(o_state),       m.st);
      check("hit_count", int'(o_hit_count),   m.hit);
      check("alarm",     int'(o_alarm),       (m.st == 2) ? 1 : 0);
      check("pulse",     int'(o_alarm_pulse), m.pulse);
      check("event_cnt", int'(o_event_count), m.evt);
      check("event_sat", int'(e2),            m.evt2);
      check("pulse_w2",  int'(p2),            m.pulse);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p1[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
    int h1[8]  = '{1, 1, 2, 2, 3, 3, 4, 4};
    int hz[8]  = '{3, 3, 2, 2, 1, 1, 0, 0};
    int p3[7]  = '{1, 1, 0, 1, 0, 1, 1};
    int h3[7]  = '{1, 2, 2, 3, 3, 4, 5};

    i_rstn = 1'b0; i_enable = 1'b0; i_window = 1'b0;
    i_detected = 1'b0; i_clear = 1'b0;
    #3;
    check("rst_state", int'(o_state), 0);
    check("rst_alarm", int'(o_alarm), 0);
    check("rst_pulse", int'(o_alarm_pulse), 0);
    check("rst_hit",   int'(o_hit_count), 0);
    check("rst_evt",   int'(o_event_count), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Disabled: stays IDLE, windows ignored; enabling discards the window.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0);

    // Five detected windows -> alarm with a single pulse.
    for (int i = 0; i < 5; i++)
      step(1, 1, 1, 0, (i == 4) ? 2 : 1, i + 1, (i == 4) ? 1 : 0);
    step(1, 0, 0, 0, 2, 5, 0);

    // Clear with coincident detected window -> HOLDOFF; 0,1,0,0 re-arms.
    step(1, 1, 1, 1, 3, 0, 0);
    step(1, 1, 0, 0, 3, 0, 0);
    step(1, 1, 1, 0, 3, 0, 0);
    step(1, 1, 0, 0, 3, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);

    // Alternating pattern peaks at 4, decays; detected without window ignored.
    for (int i = 0; i < 8; i++) step(1, 1, p1[i][0], 0, 1, h1[i], 0);
    step(1, 0, 1, 0, 1, 4, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 1, hz[i], 0);
    for (int i = 0; i < 7; i++)
      step(1, 1, p3[i][0], 0, (i == 6) ? 2 : 1, h3[i], (i == 6) ? 1 : 0);

    // Hit count stays live in ALARM, no further pulses.
    step(1, 1, 0, 0, 2, 5, 0);
    step(1, 1, 0, 0, 2, 4, 0);

    // Clear inside HOLDOFF restarts the clean-window count.
    step(1, 0, 0, 1, 3, 0, 0);
    step(1, 1, 0, 0, 3, 0, 0);
    step(1, 0, 0, 1, 3, 0, 0);
    step(1, 1, 0, 0, 3, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);

    // Enable drop flushes history.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1, i + 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1, i + 1, 0);
    // Clear in ARMED flushes and discards the coincident window.
    step(1, 1, 1, 1, 1, 0, 0);

    // Repeated alarms: 16-bit counter keeps counting, 2-bit one saturates.
    alarm_cycle(1'b1);
    alarm_cycle(1'b1);
    alarm_cycle(1'b0);
    step(1, 0, 0, 0, 2, 5, 0);

    // Asynchronous reset in the middle of a cycle during ALARM.
    @(posedge i_clk);
    #4;
    i_rstn = 1'b0;
    #1;
    check("arst_state", int'(o_state), 0);
    check("arst_alarm", int'(o_alarm), 0);
    check("arst_hit",   int'(o_hit_count), 0);
    check("arst_evt",   int'(o_event_count), 0);
    check("arst_evt2",  int'(e2), 0);
    e_evt = 0;
    e_evt2 = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Detected without window after release leaves history empty; first
    // window becomes bit 0.
    step(1, 0, 1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 1, 0);

    repeat (3) @(posedge i_clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
